// File: rtl/core_seq_ysyx.sv
// core_seq_ysyx: multi-cycle fetch/decode/execute/memory/writeback sequencer with PC, IR and perf counters
module core_seq_ysyx #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] instr,
  input  logic [2:0]  dec_ExtOp,
  input  logic        dec_RegWr,
  input  logic        dec_mRegWr,
  input  logic [1:0]  dec_MemtoReg,
  input  logic        dec_MemWr,
  input  logic [31:0] exu_next_pc,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic [31:0] pc,
  output logic        gpr_we,
  output logic        csr_we,
  output logic        commit,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] mcycle,
  output logic [31:0] minstret
);
  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  err_q, err_d;
  logic        waiting, hs, timeout, in_wb;
  always_comb begin
    waiting = state_q == FETCH_REQ || state_q == FETCH_WAIT || state_q == MEM_REQ || state_q == MEM_WAIT;
    hs = state_q == FETCH_REQ  ? ifu_req_ready :
         state_q == FETCH_WAIT ? ifu_rsp_valid :
         state_q == MEM_REQ    ? lsu_req_ready :
         state_q == MEM_WAIT   ? lsu_rsp_valid : 1'b0;
    // wait_q counts cycles already spent, so +1 includes the current one
    timeout = waiting && TIMEOUT != 8'd0 && (wait_q + 8'd1) == TIMEOUT && !hs;
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    err_d = err_q;
    mcycle_d = mcycle_q + 32'd1;
    minstret_d = minstret_q;
    case (state_q)
      FETCH_REQ:  state_d = ifu_req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: begin
        instr_d = ifu_rsp_valid ? ifu_rsp_data : instr_q;
        state_d = ifu_rsp_valid ? DECODE : FETCH_WAIT;
      end
      DECODE: begin
        state_d = dec_ExtOp == 3'b000 ? HALT : EXEC;
        err_d = dec_ExtOp == 3'b000 ? 2'b01 : err_q;
      end
      EXEC:       state_d = (dec_MemtoReg == 2'b01 || dec_MemWr) ? MEM_REQ : WB;
      MEM_REQ:    state_d = lsu_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT:   state_d = lsu_rsp_valid ? WB : MEM_WAIT;
      WB: begin
        minstret_d = minstret_q + 32'd1;
        pc_d = exu_next_pc[1:0] == 2'b00 ? exu_next_pc : pc_q;
        state_d = exu_next_pc[1:0] == 2'b00 ? FETCH_REQ : HALT;
        err_d = exu_next_pc[1:0] == 2'b00 ? err_q : 2'b10;
      end
      default: state_d = HALT;
    endcase
    if (timeout) begin
      state_d = HALT;
      err_d = 2'b11;
    end
    wait_d = state_d == state_q ? wait_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q <= RESET_PC;
      instr_q <= 32'd0;
      mcycle_q <= 32'd0;
      minstret_q <= 32'd0;
      wait_q <= 8'd0;
      err_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
      wait_q <= wait_d;
      err_q <= err_d;
    end
  end
  // state already sits in FETCH_REQ during reset, so request valids need explicit gating
  always_comb begin
    in_wb = !rst && state_q == WB;
    ifu_req_valid = !rst && state_q == FETCH_REQ;
    lsu_req_valid = !rst && state_q == MEM_REQ;
    ifu_req_addr = pc_q;
    gpr_we = in_wb && dec_RegWr;
    csr_we = in_wb && dec_mRegWr;
    commit = in_wb;
    halted = state_q == HALT;
  end
  assign instr = instr_q;
  assign pc = pc_q;
  assign err_code = err_q;
  assign mcycle = mcycle_q;
  assign minstret = minstret_q;
endmodule

// File: tb/tb_core_seq_ysyx.sv
// tb_core_seq_ysyx: randomized bus timing against a cycle-schedule reference model of the sequencer
module tb_core_seq_ysyx;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int TO = 4;
  localparam logic [31:0] ADDI = 32'h0010_0093, LW = 32'h0000_a103, SW = 32'h0020_a023;
  localparam logic [31:0] CSRW = 32'h3400_91f3, BEQ = 32'h0000_0063, JALR = 32'h0001_00e7;
  logic clk = 0, rst = 0;
  logic ifu_req_valid, ifu_req_ready = 0, ifu_rsp_valid = 0, lsu_req_valid, lsu_req_ready = 0, lsu_rsp_valid = 0;
  logic [31:0] ifu_req_addr, ifu_rsp_data = 0, instr, exu_next_pc = 0, pc, mcycle, minstret;
  logic [2:0] dec_ExtOp;
  logic dec_RegWr, dec_mRegWr, dec_MemWr, gpr_we, csr_we, commit, halted;
  logic [1:0] dec_MemtoReg, err_code;
  typedef struct packed {logic [2:0] ext; logic rwr; logic mrwr; logic [1:0] mtr; logic mwr;} dec_t;
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d = '0;
    case (w[6:0])
      7'h13, 7'h67: begin d.ext = 3'd1; d.rwr = 1; end
      7'h03: begin d.ext = 3'd1; d.rwr = 1; d.mtr = 2'b01; end
      7'h23: begin d.ext = 3'd2; d.mwr = 1; end
      7'h63: d.ext = 3'd3;
      7'h73: begin d.ext = 3'd1; d.rwr = 1; d.mrwr = 1; end
      default: d = '0;
    endcase
    return d;
  endfunction
  dec_t dd;
  assign dd = decode(instr);
  assign dec_ExtOp = dd.ext;
  assign dec_RegWr = dd.rwr;
  assign dec_mRegWr = dd.mrwr;
  assign dec_MemtoReg = dd.mtr;
  assign dec_MemWr = dd.mwr;
  always #5 clk = ~clk;
  core_seq_ysyx #(.RESET_PC(RPC), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .instr(instr), .dec_ExtOp(dec_ExtOp), .dec_RegWr(dec_RegWr), .dec_mRegWr(dec_mRegWr),
    .dec_MemtoReg(dec_MemtoReg), .dec_MemWr(dec_MemWr), .exu_next_pc(exu_next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .pc(pc), .gpr_we(gpr_we), .csr_we(csr_we), .commit(commit), .halted(halted),
    .err_code(err_code), .mcycle(mcycle), .minstret(minstret));
  logic [31:0] m_pc, m_ret, m_cyc;
  logic m_halt;
  logic [1:0] m_err;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (!rst) m_cyc++;
  endtask
  task automatic chk_all(input logic iv, input logic lv, input logic cm, input logic gw, input logic cw);
    chk("ifu_req_valid", ifu_req_valid, iv);
    chk("lsu_req_valid", lsu_req_valid, lv);
    chk("commit", commit, cm);
    chk("gpr_we", gpr_we, gw);
    chk("csr_we", csr_we, cw);
    chk("pc", pc, m_pc);
    chk("ifu_req_addr", ifu_req_addr, m_pc);
    chk("halted", halted, m_halt);
    chk("err_code", err_code, m_err);
    chk("minstret", minstret, m_ret);
    chk("mcycle", mcycle, m_cyc);
  endtask
  task automatic do_reset();
    rst = 1;
    {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = '0;
    m_pc = RPC; m_ret = 0; m_cyc = 0; m_halt = 0; m_err = 0;
    #1;
    chk_all(0, 0, 0, 0, 0);
    chk("instr_rst", instr, 32'd0);
    @(negedge clk);
    chk_all(0, 0, 0, 0, 0);
    rst = 0;
  endtask
  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = 4'($urandom);
      ifu_rsp_data = $urandom;
      #1;
      chk_all(0, 0, 0, 0, 0);
      tick();
    end
  endtask
  // Expected cycle of every handshake is derived from the stall counts; a stall of TO or more times out
  task automatic run(input logic [31:0] w, input logic [31:0] npc, input int rq, input int rs,
                     input int mq, input int ms, input bit abort_mw);
    dec_t d;
    int s[4], st[4], en[4];
    bit hs[4];
    bit to, mem, inf, inm;
    int cur, dc, wb, last;
    d = decode(w);
    mem = d.ext != 3'd0 && (d.mtr == 2'b01 || d.mwr);
    s = '{rq, rs, mq, ms};
    st = '{1, 1, 1, 1};
    en = '{0, 0, 0, 0};
    hs = '{0, 0, 0, 0};
    cur = 0; to = 0; dc = 0; wb = 0;
    for (int p = 0; p < 4 && !to; p++) begin
      if (p == 2) begin
        dc = cur + 1;
        cur += 2;
        if (d.ext == 3'd0 || !mem) break;
      end
      st[p] = cur + 1;
      hs[p] = s[p] < TO;
      cur += hs[p] ? s[p] + 1 : TO;
      en[p] = cur;
      to = !hs[p];
    end
    if (to) last = cur;
    else if (d.ext == 3'd0) last = dc;
    else begin wb = cur + 1; last = wb; end
    exu_next_pc = npc;
    for (int c = 1; c <= last; c++) begin
      if (abort_mw && c == st[3]) begin
        do_reset();
        return;
      end
      inf = c >= st[1] && c <= en[1];
      inm = c >= st[3] && c <= en[3];
      ifu_req_ready = hs[0] && c == en[0];
      ifu_rsp_valid = (hs[1] && c == en[1]) || (!inf && $urandom_range(0, 1) == 1);
      ifu_rsp_data = (hs[1] && c == en[1]) ? w : $urandom;
      lsu_req_ready = hs[2] && c == en[2];
      lsu_rsp_valid = (hs[3] && c == en[3]) || (!inm && $urandom_range(0, 1) == 1);
      #1;
      chk_all(c >= st[0] && c <= en[0], c >= st[2] && c <= en[2], c == wb, c == wb && d.rwr, c == wb && d.mrwr);
      if (c == dc) chk("instr", instr, w);
      tick();
    end
    if (to) begin m_halt = 1; m_err = 2'b11; end
    else if (d.ext == 3'd0) begin m_halt = 1; m_err = 2'b01; end
    else begin
      m_ret++;
      if (npc[1:0] == 2'b00) m_pc = npc;
      else begin m_halt = 1; m_err = 2'b10; end
    end
  endtask
  initial begin
    logic [31:0] words[5];
    logic [31:0] w;
    words = '{ADDI, LW, SW, CSRW, BEQ};
    #2;
    do_reset();
    run(ADDI, RPC + 4, 0, 0, 0, 0, 0);
    chk("addi_pc", pc, 32'h8000_0004);
    chk("addi_minstret", minstret, 32'd1);
    run(LW, m_pc + 4, 0, 0, 3, 1, 0);
    run(SW, m_pc + 4, 1, 2, 0, 3, 0);
    run(CSRW, m_pc + 4, 2, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      w = words[$urandom_range(0, 4)];
      run(w, m_pc + {$urandom_range(0, 63), 2'b00}, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    run(JALR, 32'h8000_0102, 0, 0, 0, 0, 0);
    halt_idle(3);
    force dut.mcycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.mcycle_q;
    m_cyc = 32'hFFFF_FFFE;
    halt_idle(3);
    chk("mcycle_wrap", mcycle, 32'd1);
    do_reset();
    run(32'h0000_0000, RPC + 4, 1, 1, 0, 0, 0);
    halt_idle(4);
    do_reset();
    run(ADDI, RPC + 4, 4, 0, 0, 0, 0);
    halt_idle(3);
    do_reset();
    run(ADDI, RPC + 4, 3, 0, 0, 0, 0);
    run(ADDI, m_pc + 8, 0, 3, 0, 0, 0);
    run(LW, m_pc + 4, 0, 0, 0, 5, 0);
    halt_idle(2);
    do_reset();
    run(SW, m_pc + 4, 0, 0, 3, 0, 0);
    run(LW, m_pc + 4, 1, 1, 1, 1, 1);
    run(ADDI, RPC + 4, 0, 0, 0, 0, 0);
    run(LW, m_pc + 4, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_seq_ysyx.md
# core_seq_ysyx

Multi-cycle sequencer for the single-issue RV32 NPC core. Owns the PC and instruction register and drives the fetch and load/store request handshakes. It steps each instruction through fetch, decode, execute, memory and writeback, using the decoder's control outputs, and gates the GPR and CSR write enables. It also keeps the cycle and retired-instruction counters and stops the core on illegal instructions, misaligned PCs and bus timeouts.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- TIMEOUT, 8'd255, maximum cycles spent in any one bus-wait state; 0 disables the timeout.

- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- ifu_req_valid  out  1  fetch request valid
- ifu_req_addr  out  32  fetch address, equal to pc
- ifu_req_ready  in  1  fetch request accepted
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_data  in  32  fetched instruction
- instr  out  32  instruction register, sent to the decoder
- dec_ExtOp  in  3  decoder instruction type; 3'b000 means illegal
- dec_RegWr  in  1  decoder GPR write request
- dec_mRegWr  in  1  decoder CSR write request
- dec_MemtoReg  in  2  2'b01 marks a load
- dec_MemWr  in  1  marks a store
- exu_next_pc  in  32  next PC from the branch/ALU path, valid in WB
- lsu_req_valid  out  1  load/store request valid
- lsu_req_ready  in  1  load/store request accepted
- lsu_rsp_valid  in  1  load data returned, or store completed
- pc  out  32  current PC
- gpr_we  out  1  GPR write strobe
- csr_we  out  1  CSR write strobe
- commit  out  1  one-cycle pulse per retired instruction
- halted  out  1  core stopped; remains set until reset
- err_code  out  2  00 none, 01 illegal instruction, 10 misaligned next PC, 11 timeout
- mcycle  out  32  cycle counter
- minstret  out  32  retired-instruction counter

## Operation
- Reset values: state FETCH_REQ, pc=RESET_PC, instr=0, mcycle=0, minstret=0, halted=0, err_code=00. All strobes and request valids are 0 during reset.
- FSM states: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH_REQ: ifu_req_valid=1, ifu_req_addr=pc. Valid and address stay stable until ifu_req_ready. On valid&ready, go to FETCH_WAIT.
- FETCH_WAIT: on ifu_rsp_valid, load instr from ifu_rsp_data and go to DECODE.
- ifu_rsp_valid outside FETCH_WAIT and lsu_rsp_valid outside MEM_WAIT are ignored.
- DECODE: the decoder settles combinationally from instr.
  - dec_ExtOp==000: go to HALT with err_code=01; pc stays at the faulting instruction.
  - Otherwise go to EXEC.
- EXEC: go to MEM_REQ if dec_MemtoReg==01 or dec_MemWr=1, otherwise to WB.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid, go to WB.
- WB, one cycle:
  - gpr_we=dec_RegWr, csr_we=dec_mRegWr, commit=1, minstret increments.
  - exu_next_pc[1:0]==00: pc<=exu_next_pc, go to FETCH_REQ.
  - Otherwise: pc unchanged, go to HALT with err_code=10. The instruction still commits.
- HALT: terminal; only reset leaves it. halted=1 and all strobes and valids are 0.
- Timeout: one 8-bit wait counter, cleared on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT, incremented each cycle spent in them. If it equals TIMEOUT while TIMEOUT≠0 and the handshake did not complete that cycle, go to HALT with err_code=11. A handshake completing in the same cycle the count hits TIMEOUT wins.
- mcycle increments every cycle out of reset, HALT included. Both counters wrap from 32'hFFFF_FFFF to 0 with no flag.
- Asserting rst in any state, including mid-handshake, aborts immediately and returns every register to its reset value. Requesters must discard outstanding transactions.

## Timing
- ALU, branch or CSR instruction with zero-wait buses (ready in the request cycle, response the next cycle): 5 cycles FETCH_REQ→WB, so commit every 5th cycle.
- Load or store with zero-wait buses: 7 cycles.
- Each request-side wait cycle and each response-side wait cycle adds exactly 1 cycle.
- The pc update, instr load and counter updates become visible the cycle after the qualifying edge.
- gpr_we, csr_we and commit are high only in WB. They are never high in consecutive cycles.
- ifu_req_valid and lsu_req_valid are never high together.

## Test plan
- Reset, then an addi with ifu_req_ready=1 and response one cycle later → ifu_req_addr=32'h8000_0000; commit and gpr_we in cycle 5; pc=32'h8000_0004; minstret=1.
- lw with lsu_req_ready held low 3 cycles and lsu_rsp_valid 2 cycles after accept → commit in cycle 7+3+1=11; lsu_req_valid stays high through the stall.
- Illegal word 32'h0000_0000 (ExtOp=000) → halted=1, err_code=01, pc unchanged, no commit, no further ifu_req_valid.
- jalr with exu_next_pc=32'h8000_0102 → commit=1, gpr_we=1, then halted with err_code=10 and pc still at the jalr.
- TIMEOUT=4 with ifu_req_ready held 0 → HALT with err_code=11 after 4 wait cycles. Repeat with ready rising in the 4th cycle → no error and fetch proceeds.
- rst pulsed in MEM_WAIT → all outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
- mcycle preloaded near the limit (force to 32'hFFFF_FFFE) → reads 0 two cycles later.
